// File: rtl/bit_count_acc.sv
// Population-count accumulator: one pipelined popcount stage feeding a packet accumulator and a one-deep result register.
// Define BIT_COUNT_ACC_SATURATE_EN to clamp the accumulator at all-ones on overflow instead of wrapping.
module bit_count_acc #(
    parameter int N_IN  = 7,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_bits,
    input  logic             in_last,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_ovf
);
    localparam int CNT_W = $clog2(N_IN + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [N_IN-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < N_IN; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    function automatic logic [ACC_W-1:0] limit_sum(input logic [ACC_W:0] s);
`ifdef BIT_COUNT_ACC_SATURATE_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    logic             vld_p1_q, vld_p1_d;
    logic [CNT_W-1:0] cnt_p1_q, cnt_p1_d;
    logic             last_p1_q, last_p1_d;
    logic             mode_p1_q, mode_p1_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             term_p1;
    logic             s1_consumed;
    logic [ACC_W:0]   sum_p1;
    logic [ACC_W-1:0] sum_lim_p1;

    assign term_p1     = !mode_p1_q || last_p1_q;
    assign s1_consumed = vld_p1_q && (!term_p1 || !out_valid_q || out_ready);
    assign in_ready    = !vld_p1_q || s1_consumed;
    assign sum_p1      = {1'b0, acc_q} + (ACC_W + 1)'(cnt_p1_q);
    assign sum_lim_p1  = limit_sum(sum_p1);

    always_comb begin
        vld_p1_d    = vld_p1_q;
        cnt_p1_d    = cnt_p1_q;
        last_p1_d   = last_p1_q;
        mode_p1_d   = mode_p1_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        // Stage 2: accumulate or emit the stage-1 beat
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (s1_consumed) begin
            if (term_p1) begin
                out_valid_d = 1'b1;
                out_count_d = sum_lim_p1;
                out_ovf_d   = acc_ovf_q | sum_p1[ACC_W];
                acc_d       = '0;
                acc_ovf_d   = 1'b0;
            end else begin
                acc_d       = sum_lim_p1;
                acc_ovf_d   = acc_ovf_q | sum_p1[ACC_W];
            end
        end

        // Stage 1: capture popcount of the accepted beat
        if (in_valid && in_ready) begin
            vld_p1_d  = 1'b1;
            cnt_p1_d  = popcount(in_bits);
            last_p1_d = in_last;
            mode_p1_d = acc_mode;
        end else if (s1_consumed) begin
            vld_p1_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q    <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Stage-1 payload is qualified by vld_p1_q, so it needs no reset
    always_ff @(posedge clk) begin
        cnt_p1_q  <= cnt_p1_d;
        last_p1_q <= last_p1_d;
        mode_p1_q <= mode_p1_d;
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bit_count_acc.sv
// Randomized and directed bench for bit_count_acc (N_IN=7, ACC_W=8) against a packet-sum scoreboard.
module tb_bit_count_acc;
    localparam int N_IN  = 7;
    localparam int ACC_W = 8;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_bits;
    logic             in_last;
    logic             acc_mode;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_ovf;

    bit_count_acc #(.N_IN(N_IN), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .in_last(in_last), .acc_mode(acc_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: a packet's result is the plain integer sum of popcounts, reduced at the end
    int  model_total = 0;
    int  exp_cnt_q[$];
    int  exp_ovf_q[$];
    int  results_seen = 0;
    bit  saw_not_ready = 0;
    bit  prev_hold = 0;
    logic [ACC_W-1:0] prev_cnt;
    logic             prev_ovf;

    function automatic int packet_value(input int total);
`ifdef BIT_COUNT_ACC_SATURATE_EN
        return (total > MAXV) ? MAXV : total;
`else
        return total % (MAXV + 1);
`endif
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            model_total = 0;
            exp_cnt_q.delete();
            exp_ovf_q.delete();
            prev_hold = 0;
        end else begin
            if (!in_ready) saw_not_ready = 1;
            if (prev_hold) begin
                check("hold_count", 32'(out_count), 32'(prev_cnt));
                check("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
            end
            prev_hold = out_valid && !out_ready;
            prev_cnt  = out_count;
            prev_ovf  = out_ovf;
            if (out_valid && out_ready) begin
                results_seen++;
                if (exp_cnt_q.size() == 0) begin
                    check("unexpected_result", 32'(out_count), 32'hFFFF_FFFF);
                end else begin
                    check("out_count", 32'(out_count), 32'(exp_cnt_q.pop_front()));
                    check("out_ovf", 32'(out_ovf), 32'(exp_ovf_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                model_total += $countones(in_bits);
                if (!acc_mode || in_last) begin
                    exp_cnt_q.push_back(packet_value(model_total));
                    exp_ovf_q.push_back(model_total > MAXV ? 1 : 0);
                    model_total = 0;
                end
            end
        end
    end

    task automatic send(input logic [N_IN-1:0] b, input logic l, input logic m);
        int  n;
        logic ok;
        in_valid = 1'b1; in_bits = b; in_last = l; acc_mode = m;
        n = 0;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int base;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_bits = '0; in_last = 1'b0;
        acc_mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        check("rst_out_ovf", 32'(out_ovf), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Pass mode: two back-to-back beats, two-edge latency
        in_valid = 1'b1; in_bits = 7'b1111111; acc_mode = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        in_bits = 7'b0000101;
        check("lat_e1_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_e2_valid", 32'(out_valid), 32'(1));
        check("lat_e2_count", 32'(out_count), 32'(7));
        check("lat_e2_ovf", 32'(out_ovf), 32'(0));
        @(posedge clk); #1;
        check("lat_e3_valid", 32'(out_valid), 32'(1));
        check("lat_e3_count", 32'(out_count), 32'(2));
        @(posedge clk); #1;
        check("lat_e4_valid", 32'(out_valid), 32'(0));

        // Accumulate four beats into one result
        base = results_seen;
        for (int i = 0; i < 4; i++) send(7'b1010101, i == 3, 1'b1);
        idle(4);
        check("acc_results", 32'(results_seen - base), 32'(1));

        // Mode-0 beat closes an accumulating packet
        base = results_seen;
        send(7'b1111111, 1'b0, 1'b1);
        send(7'b1111111, 1'b0, 1'b1);
        send(7'b0000001, 1'b0, 1'b0);
        idle(4);
        check("mode0_term_results", 32'(results_seen - base), 32'(1));

        // Overflow: 37 full beats sum to 259
        base = results_seen;
        for (int i = 0; i < 37; i++) send(7'b1111111, i == 36, 1'b1);
        idle(4);
        check("ovf_results", 32'(results_seen - base), 32'(1));
`ifdef BIT_COUNT_ACC_SATURATE_EN
        check("ovf_direct_count", 32'(out_count), 32'(255));
`else
        check("ovf_direct_count", 32'(out_count), 32'(3));
`endif
        check("ovf_direct_flag", 32'(out_ovf), 32'(1));

        // Backpressure with continuous pass-mode input
        base = results_seen;
        saw_not_ready = 0;
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(7'($urandom), 1'b0, 1'b0);
            begin repeat (5) @(posedge clk); #1 out_ready = 1'b1; end
        join
        idle(5);
        check("bp_in_ready_dropped", 32'(saw_not_ready), 32'(1));
        check("bp_results", 32'(results_seen - base), 32'(8));

        // Reset mid-packet discards the partial sum
        send(7'b0000011, 1'b0, 1'b1);
        send(7'b0000011, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("rst2_in_ready", 32'(in_ready), 32'(1));
        check("rst2_out_valid", 32'(out_valid), 32'(0));
        base = results_seen;
        send(7'b0000001, 1'b1, 1'b1);
        idle(4);
        check("rst2_results", 32'(results_seen - base), 32'(1));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_bits   = 7'($urandom);
            in_last   = ($urandom_range(3) == 0);
            acc_mode  = ($urandom_range(1) == 1);
            out_ready = ($urandom_range(3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        begin
            int n = 0;
            while ((exp_cnt_q.size() != 0 || out_valid) && n < 50) begin
                @(posedge clk); #1; n++;
            end
        end
        check("drain_empty", 32'(exp_cnt_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
